balance_txn_arbiter: RTL and testbench

- Shares the single account-balance RAM between NUM_REQ transaction requesters (ATM front-ends, deposit unit, audit port).
- Performs atomic read-modify-write transactions (read, withdraw, deposit) one at a time.
- Uses round-robin arbitration, so no requester can corrupt another's update or starve it.
- Sits between the ATM control FSMs and the balance RAM; it is the only writer of that RAM.

---
 rtl/balance_txn_arbiter_pkg.sv | 27 ++
 rtl/balance_txn_arbiter_rr_arbiter.sv | 30 +++
 rtl/balance_txn_arbiter.sv | 134 +++++++++++++
 tb/tb_balance_txn_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/balance_txn_arbiter_pkg.sv
// balance_txn_arbiter_pkg: op and state encodings plus default widths shared by the
// balance arbiter and the other shared-resource blocks
package balance_txn_arbiter_pkg;
   localparam int DEF_NUM_REQ  = 4;
   localparam int DEF_NUM_ACCT = 5;
   localparam int DEF_ID_W     = 4;
   localparam int DEF_BAL_W    = 10;
   localparam int DEF_VAL_W    = 5;

   typedef enum logic [1:0] {
      OP_READ     = 2'b00,
      OP_WITHDRAW = 2'b01,
      OP_DEPOSIT  = 2'b10,
      OP_RSVD     = 2'b11
   } op_e;

   typedef enum logic [3:0] {
      IDLE = 4'b0001,
      READ = 4'b0010,
      CALC = 4'b0100,
      RESP = 4'b1000
   } state_e;

   function automatic int ptr_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/balance_txn_arbiter_rr_arbiter.sv
// rr_arbiter: combinational one-hot round-robin pick, searching from the
// requester after Ptr and wrapping around
module rr_arbiter
   import balance_txn_arbiter_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   localparam int PTR_W = ptr_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] Req,
   input  logic [PTR_W-1:0]   Ptr,
   output logic [NUM_REQ-1:0] Gnt,
   output logic [PTR_W-1:0]   GntIdx
);
   logic [PTR_W-1:0] idx;

   always_comb begin
      Gnt = '0;
      GntIdx = '0;
      idx = '0;
      // scan farthest-first so the nearest requester after Ptr is the last hit
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = PTR_W'((int'(Ptr) + k) % NUM_REQ);
         if (Req[idx]) begin
            Gnt = '0;
            Gnt[idx] = 1'b1;
            GntIdx = idx;
         end
      end
   end
endmodule

// File: rtl/balance_txn_arbiter.sv
// balance_txn_arbiter: round-robin arbiter serialising atomic read-modify-write
// balance transactions from NUM_REQ requesters onto the single balance RAM
module balance_txn_arbiter
   import balance_txn_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int NUM_ACCT = DEF_NUM_ACCT,
   parameter int ID_W     = DEF_ID_W,
   parameter int BAL_W    = DEF_BAL_W,
   parameter int VAL_W    = DEF_VAL_W
) (
   input  logic                     Clock,
   input  logic                     ClearN,
   input  logic [NUM_REQ-1:0]       ReqValid,
   input  logic [2*NUM_REQ-1:0]     ReqOp,
   input  logic [ID_W*NUM_REQ-1:0]  ReqID,
   input  logic [VAL_W*NUM_REQ-1:0] ReqValue,
   output logic [NUM_REQ-1:0]       Grant,
   output logic [NUM_REQ-1:0]       RspValid,
   output logic [BAL_W-1:0]         RspBalance,
   output logic                     ErrFunds,
   output logic                     ErrOvf,
   output logic                     ErrID,
   output logic [ID_W-1:0]          MemAddr,
   output logic                     MemRdEn,
   input  logic [BAL_W-1:0]         MemRdData,
   output logic                     MemWrEn,
   output logic [BAL_W-1:0]         MemWrData,
   output logic                     Busy,
   output logic [15:0]              TxnCount
);
   localparam int PTR_W = ptr_w(NUM_REQ);
   localparam int BX = BAL_W + 1;
   localparam logic [ID_W:0] ACCT_LIM = NUM_ACCT[ID_W:0];

   state_e state, state_nxt;
   logic [PTR_W-1:0] ptr, pick_idx;
   logic [NUM_REQ-1:0] pick, win;
   logic [1:0] req_op;
   logic [ID_W-1:0] req_id;
   logic [VAL_W-1:0] req_val;
   op_e op_q;
   logic [ID_W-1:0] id_q;
   logic [VAL_W-1:0] val_q;
   logic [BAL_W-1:0] bal_q, new_bal, diff;
   logic wr_q, ef_q, eo_q, ei_q;
   logic id_ok, do_wd, do_dep, fund_ok, wr_ok;
   logic [BAL_W:0] val_x, sum;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .Req(ReqValid),
      .Ptr(ptr),
      .Gnt(pick),
      .GntIdx(pick_idx)
   );

   always_comb begin
      req_op = '0;
      req_id = '0;
      req_val = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[i]) begin
            req_op = ReqOp[2*i +: 2];
            req_id = ReqID[ID_W*i +: ID_W];
            req_val = ReqValue[VAL_W*i +: VAL_W];
         end
      end
   end

   // the reserved op falls through every test below and behaves as a read
   assign id_ok = {1'b0, id_q} < ACCT_LIM;
   assign do_wd = op_q == OP_WITHDRAW;
   assign do_dep = op_q == OP_DEPOSIT;
   assign val_x = BX'(val_q);
   assign sum = {1'b0, MemRdData} + val_x;
   assign diff = MemRdData - val_x[BAL_W-1:0];
   assign fund_ok = {1'b0, MemRdData} >= val_x;
   assign wr_ok = id_ok && (do_wd ? fund_ok : do_dep && !sum[BAL_W]);
   assign new_bal = !id_ok ? '0 : !wr_ok ? MemRdData : do_wd ? diff : sum[BAL_W-1:0];

   always_ff @(posedge Clock or negedge ClearN) begin
      if (!ClearN) state <= IDLE;
      else state <= state_nxt;
   end

   always_comb begin
      state_nxt = state == IDLE ? (|ReqValid ? READ : IDLE) :
                  state == READ ? CALC :
                  state == CALC ? RESP : IDLE;
      Busy = state != IDLE;
      Grant = state == READ ? win : '0;
      RspValid = state == RESP ? win : '0;
      RspBalance = state == RESP ? bal_q : '0;
      ErrFunds = state == RESP && ef_q;
      ErrOvf = state == RESP && eo_q;
      ErrID = state == RESP && ei_q;
      MemRdEn = state == READ && id_ok;
      MemWrEn = state == RESP && wr_q;
      MemWrData = MemWrEn ? bal_q : '0;
      MemAddr = (state == READ || MemWrEn) ? id_q : '0;
   end

   always_ff @(posedge Clock or negedge ClearN) begin
      if (!ClearN) begin
         ptr <= PTR_W'(NUM_REQ - 1);
         win <= '0;
         op_q <= OP_READ;
         id_q <= '0;
         val_q <= '0;
         bal_q <= '0;
         wr_q <= 1'b0;
         ef_q <= 1'b0;
         eo_q <= 1'b0;
         ei_q <= 1'b0;
         TxnCount <= '0;
      end else begin
         if (state == IDLE && |ReqValid) begin
            ptr <= pick_idx;
            win <= pick;
            op_q <= op_e'(req_op);
            id_q <= req_id;
            val_q <= req_val;
         end
         if (state == CALC) begin
            bal_q <= new_bal;
            wr_q <= wr_ok;
            ei_q <= !id_ok;
            ef_q <= id_ok && do_wd && !fund_ok;
            eo_q <= id_ok && do_dep && sum[BAL_W];
         end
         if (state == RESP && wr_q) TxnCount <= TxnCount + 16'd1;
      end
   end
endmodule

// File: tb/tb_balance_txn_arbiter.sv
// tb_balance_txn_arbiter: directed transactions against a RAM model; expected
// responses are queued at issue and popped by a monitor on every response
module tb_balance_txn_arbiter;
   import balance_txn_arbiter_pkg::*;

   logic Clock = 1'b0;
   logic ClearN = 1'b0;
   logic [3:0] ReqValid = '0;
   logic [7:0] ReqOp = '0;
   logic [15:0] ReqID = '0;
   logic [19:0] ReqValue = '0;
   logic [3:0] Grant, RspValid;
   logic [9:0] RspBalance;
   logic ErrFunds, ErrOvf, ErrID;
   logic [3:0] MemAddr;
   logic MemRdEn;
   logic [9:0] MemRdData = '0;
   logic MemWrEn;
   logic [9:0] MemWrData;
   logic Busy;
   logic [15:0] TxnCount;

   logic [9:0] ram [16];

   typedef struct {
      int r;
      int id;
      int bal;
      logic ef;
      logic eo;
      logic ei;
      logic wr;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int total = 0;
   int passed = 0;
   int exp_txn = 0;

   always #5 Clock = ~Clock;

   balance_txn_arbiter dut (
      .Clock(Clock),
      .ClearN(ClearN),
      .ReqValid(ReqValid),
      .ReqOp(ReqOp),
      .ReqID(ReqID),
      .ReqValue(ReqValue),
      .Grant(Grant),
      .RspValid(RspValid),
      .RspBalance(RspBalance),
      .ErrFunds(ErrFunds),
      .ErrOvf(ErrOvf),
      .ErrID(ErrID),
      .MemAddr(MemAddr),
      .MemRdEn(MemRdEn),
      .MemRdData(MemRdData),
      .MemWrEn(MemWrEn),
      .MemWrData(MemWrData),
      .Busy(Busy),
      .TxnCount(TxnCount)
   );

   always @(posedge Clock) begin
      if (MemRdEn) MemRdData <= ram[MemAddr];
      if (MemWrEn) ram[MemAddr] = MemWrData;
   end

   // requesters drop their request on seeing their grant
   always @(negedge Clock) ReqValid = ReqValid & ~Grant;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   always @(negedge Clock) begin
      if (RspValid != 0 || MemWrEn) begin
         if (sb.size() == 0) begin
            total++;
            $display("FAIL unexpected_rsp: RspValid=%b MemWrEn=%b expected none", RspValid, MemWrEn);
         end else begin
            e = sb.pop_front();
            chk("rsp_valid", RspValid, 1 << e.r);
            chk("rsp_balance", RspBalance, e.bal);
            chk("err_funds", ErrFunds, e.ef);
            chk("err_ovf", ErrOvf, e.eo);
            chk("err_id", ErrID, e.ei);
            chk("mem_wr_en", MemWrEn, e.wr);
            if (e.wr) begin
               chk("mem_wr_data", MemWrData, e.bal);
               chk("mem_wr_addr", MemAddr, e.id);
            end
         end
      end
   end

   task automatic issue(input int r, input logic [1:0] op, input int id, input int val);
      ReqOp[r*2 +: 2] = op;
      ReqID[r*4 +: 4] = 4'(id);
      ReqValue[r*5 +: 5] = 5'(val);
      ReqValid[r] = 1'b1;
   endtask

   task automatic expect_rsp(input int r, input int id, input int bal,
                             input logic ef, input logic eo, input logic ei, input logic wr);
      exp_t x;
      x.r = r;
      x.id = id;
      x.bal = bal;
      x.ef = ef;
      x.eo = eo;
      x.ei = ei;
      x.wr = wr;
      sb.push_back(x);
      if (wr) exp_txn++;
   endtask

   task automatic single(input string nm, input int r, input logic [1:0] op, input int id,
                         input int val, input int bal,
                         input logic ef, input logic eo, input logic ei, input logic wr);
      issue(r, op, id, val);
      expect_rsp(r, id, bal, ef, eo, ei, wr);
      @(negedge Clock);
      chk({nm, "_grant"}, Grant, 1 << r);
      chk({nm, "_rd_en"}, MemRdEn, !ei);
      chk({nm, "_busy"}, Busy, 1);
      @(negedge Clock);
      chk({nm, "_calc_no_wr"}, MemWrEn, 0);
      @(negedge Clock);
      chk({nm, "_rsp_timing"}, RspValid, 1 << r);
      @(negedge Clock);
      chk({nm, "_txn_count"}, TxnCount, exp_txn);
      chk({nm, "_idle"}, Busy, 0);
      if (!ei) chk({nm, "_ram"}, ram[id], bal);
   endtask

   task automatic wait_grant(input string nm, input int r, input int gap);
      int n = 0;
      do begin
         @(negedge Clock);
         n++;
      end while (Grant == 0 && n < 12);
      chk({nm, "_grant"}, Grant, 1 << r);
      chk({nm, "_gap"}, n, gap);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) ram[i] = '0;
      ram[1] = 10'd10;
      ram[2] = 10'd500;
      ram[3] = 10'd1020;
      ram[4] = 10'd333;
      repeat (2) @(negedge Clock);
      chk("rst_busy", Busy, 0);
      chk("rst_grant", Grant, 0);
      chk("rst_rsp", RspValid, 0);
      chk("rst_txn", TxnCount, 0);
      chk("rst_mem_en", {MemRdEn, MemWrEn}, 0);
      chk("rst_bal", RspBalance, 0);
      chk("rst_err", {ErrFunds, ErrOvf, ErrID}, 0);
      ClearN = 1'b1;

      single("wd", 0, OP_WITHDRAW, 2, 20, 480, 0, 0, 0, 1);
      single("nsf", 1, OP_WITHDRAW, 1, 11, 10, 1, 0, 0, 0);
      single("wd_all", 1, OP_WITHDRAW, 1, 10, 0, 0, 0, 0, 1);
      single("dep", 2, OP_DEPOSIT, 3, 3, 1023, 0, 0, 0, 1);
      single("ovf", 2, OP_DEPOSIT, 3, 1, 1023, 0, 1, 0, 0);
      single("dep0", 3, OP_DEPOSIT, 3, 0, 1023, 0, 0, 0, 1);
      single("rsvd", 0, 2'b11, 2, 7, 480, 0, 0, 0, 0);
      single("badid", 0, OP_DEPOSIT, 7, 5, 0, 0, 0, 1, 0);
      single("id5", 1, OP_READ, 5, 0, 0, 0, 0, 1, 0);
      single("id4", 3, OP_READ, 4, 0, 333, 0, 0, 0, 0);

      ram[0] = 10'd100;
      for (int i = 0; i < 4; i++) begin
         issue(i, OP_WITHDRAW, 0, 1);
         expect_rsp(i, 0, 99 - i, 0, 0, 0, 1);
      end
      for (int i = 0; i < 4; i++) wait_grant("fair1", i, i == 0 ? 1 : 4);
      repeat (3) @(negedge Clock);
      chk("fair1_ram", ram[0], 96);
      chk("fair1_txn", TxnCount, exp_txn);

      for (int i = 0; i < 4; i++) begin
         issue(i, OP_WITHDRAW, 0, 1);
         expect_rsp(i, 0, 95 - i, 0, 0, 0, 1);
      end
      wait_grant("fair2", 0, 1);
      #1;
      issue(0, OP_WITHDRAW, 0, 1);
      expect_rsp(0, 0, 91, 0, 0, 0, 1);
      for (int i = 1; i < 4; i++) wait_grant("fair2", i, 4);
      wait_grant("fair2_reissue", 0, 4);
      repeat (3) @(negedge Clock);
      chk("fair2_ram", ram[0], 91);

      issue(0, OP_WITHDRAW, 2, 30);
      @(negedge Clock);
      chk("abort_grant", Grant, 1);
      @(negedge Clock);
      ClearN = 1'b0;
      #1;
      chk("abort_busy", Busy, 0);
      chk("abort_rsp", RspValid, 0);
      chk("abort_mem_en", {MemRdEn, MemWrEn}, 0);
      chk("abort_addr", MemAddr, 0);
      chk("abort_txn", TxnCount, 0);
      chk("abort_bal", RspBalance, 0);
      chk("abort_err", {ErrFunds, ErrOvf, ErrID}, 0);
      repeat (2) @(negedge Clock);
      ClearN = 1'b1;
      exp_txn = 0;
      chk("abort_ram", ram[2], 480);
      issue(0, OP_READ, 2, 0);
      expect_rsp(0, 2, 480, 0, 0, 0, 0);
      issue(1, OP_DEPOSIT, 1, 5);
      expect_rsp(1, 1, 5, 0, 0, 0, 1);
      wait_grant("post_reset", 0, 1);
      wait_grant("post_reset", 1, 4);
      repeat (3) @(negedge Clock);
      chk("post_reset_txn", TxnCount, exp_txn);
      chk("post_reset_ram", ram[1], 5);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge Clock);
      chk("sb_drain", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
